// File: rtl/menu_selector_if.sv
// Front-panel menu bus: button levels and enable in, selection state out.
interface menu_selector_if #(
  parameter int unsigned IDX_W = 2
);

  logic             enable;
  logic             btn_left;
  logic             btn_right;
  logic             btn_confirm;
  logic [IDX_W-1:0] index;
  logic [63:0]      popup_message;
  logic             changed;
  logic [IDX_W-1:0] choice;
  logic             choice_valid;

  // Driver side: the game FSM and debounced buttons.
  modport master (
    output enable, btn_left, btn_right, btn_confirm,
    input  index, popup_message, changed, choice, choice_valid
  );

  // Selector side.
  modport slave (
    input  enable, btn_left, btn_right, btn_confirm,
    output index, popup_message, changed, choice, choice_valid
  );

endinterface

// File: rtl/menu_selector.sv
// N-option menu selector: steps a registered index on left/right presses,
// publishes the option label and latches a confirmed choice.
// Optional hold-to-repeat stepping is compiled in with MENU_SELECTOR_REPEAT_EN.
module menu_selector #(
  parameter int unsigned                   NUM_OPTIONS  = 3,
  parameter int unsigned                   IDX_W        = 2,
  parameter int unsigned                   RESET_INDEX  = 0,
  parameter bit                            WRAP         = 1'b0,
  parameter logic [NUM_OPTIONS*64-1:0]     LABELS       = {{32'd0, "Hard"},
                                                           {16'd0, "Medium"},
                                                           {32'd0, "Easy"}},
  parameter int unsigned                   REPEAT_DELAY = 24,
  parameter int unsigned                   REPEAT_RATE  = 8
) (
  input  logic              clk,
  input  logic              rst,
  menu_selector_if.slave    bus
);

  localparam logic [IDX_W-1:0] MAX_IDX = IDX_W'(NUM_OPTIONS - 1);
  localparam logic [IDX_W-1:0] RST_IDX = IDX_W'(RESET_INDEX);

  // Elaboration-time parameter sanity checks.
  if (NUM_OPTIONS < 2 || NUM_OPTIONS > 16) begin : g_bad_num_options
    $error("menu_selector: NUM_OPTIONS must be 2..16");
  end
  if ((1 << IDX_W) < NUM_OPTIONS) begin : g_bad_idx_w
    $error("menu_selector: IDX_W too narrow for NUM_OPTIONS");
  end
  if (RESET_INDEX >= NUM_OPTIONS) begin : g_bad_reset_index
    $error("menu_selector: RESET_INDEX must be below NUM_OPTIONS");
  end
  if (REPEAT_DELAY == 0 || REPEAT_RATE == 0) begin : g_bad_repeat
    $error("menu_selector: REPEAT_DELAY and REPEAT_RATE must be nonzero");
  end

  // Label lookup; indices outside the table never occur.
  function automatic logic [63:0] label_of(input logic [IDX_W-1:0] idx);
    logic [63:0] lbl;
    lbl = '0;
    for (int i = 0; i < int'(NUM_OPTIONS); i++) begin
      if (idx == IDX_W'(i)) lbl = LABELS[64*i +: 64];
    end
    return lbl;
  endfunction

  logic             prev_left_q;
  logic             prev_right_q;
  logic             prev_confirm_q;
  logic [IDX_W-1:0] index_q;
  logic [63:0]      popup_q;
  logic             changed_q;
  logic [IDX_W-1:0] choice_q;
  logic             choice_valid_q;

  logic             press_left_c;
  logic             press_right_c;
  logic             press_confirm_c;
  logic             edge_up_c;
  logic             edge_dn_c;
  logic             step_up_c;
  logic             step_dn_c;
  logic             confirm_c;

  logic [IDX_W-1:0] index_d;
  logic [63:0]      popup_d;
  logic             changed_d;
  logic [IDX_W-1:0] choice_d;
  logic             choice_valid_d;

  // Rising-edge detection and press qualification.
  always_comb begin
    press_left_c    = bus.btn_left    & ~prev_left_q;
    press_right_c   = bus.btn_right   & ~prev_right_q;
    press_confirm_c = bus.btn_confirm & ~prev_confirm_q;
    edge_up_c       = bus.enable & press_right_c & ~press_left_c;
    edge_dn_c       = bus.enable & press_left_c  & ~press_right_c;
    confirm_c       = bus.enable & press_confirm_c;
  end

`ifdef MENU_SELECTOR_REPEAT_EN
  localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned CNT_W   = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;

  logic             rpt_active_q;
  logic             rpt_active_d;
  logic [CNT_W-1:0] rpt_cnt_q;
  logic [CNT_W-1:0] rpt_cnt_d;
  logic             rpt_fire_c;
  logic             hold_one_c;

  // Countdown to the next auto-repeat step while exactly one direction is held.
  always_comb begin
    rpt_active_d = rpt_active_q;
    rpt_cnt_d    = rpt_cnt_q;
    rpt_fire_c   = 1'b0;
    hold_one_c   = bus.enable & (bus.btn_left ^ bus.btn_right);
    if (!hold_one_c) begin
      rpt_active_d = 1'b0;
      rpt_cnt_d    = '0;
    end else if (edge_up_c | edge_dn_c) begin
      rpt_active_d = 1'b1;
      rpt_cnt_d    = CNT_W'(REPEAT_DELAY - 1);
    end else if (rpt_active_q) begin
      if (rpt_cnt_q == '0) begin
        rpt_fire_c = 1'b1;
        rpt_cnt_d  = CNT_W'(REPEAT_RATE - 1);
      end else begin
        rpt_cnt_d  = rpt_cnt_q - CNT_W'(1);
      end
    end
    step_up_c = edge_up_c | (rpt_fire_c & bus.btn_right);
    step_dn_c = edge_dn_c | (rpt_fire_c & bus.btn_left);
  end

  // Repeat counter state.
  always_ff @(posedge clk) begin
    if (rst) begin
      rpt_active_q <= 1'b0;
      rpt_cnt_q    <= '0;
    end else begin
      rpt_active_q <= rpt_active_d;
      rpt_cnt_q    <= rpt_cnt_d;
    end
  end
`else
  // Only press edges step the index.
  always_comb begin
    step_up_c = edge_up_c;
    step_dn_c = edge_dn_c;
  end
`endif

  // Next selection state with wrap/saturate at the ends.
  always_comb begin
    index_d        = index_q;
    choice_d       = choice_q;
    choice_valid_d = 1'b0;
    if (step_up_c) begin
      index_d = (index_q == MAX_IDX) ? (WRAP ? IDX_W'(0) : index_q) : index_q + IDX_W'(1);
    end else if (step_dn_c) begin
      index_d = (index_q == IDX_W'(0)) ? (WRAP ? MAX_IDX : index_q) : index_q - IDX_W'(1);
    end
    if (confirm_c) begin
      choice_d       = index_q;
      choice_valid_d = 1'b1;
    end
    changed_d = (index_d != index_q);
    popup_d   = label_of(index_d);
  end

  // Selection and button-history registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_left_q    <= 1'b0;
      prev_right_q   <= 1'b0;
      prev_confirm_q <= 1'b0;
      index_q        <= RST_IDX;
      popup_q        <= label_of(RST_IDX);
      changed_q      <= 1'b0;
      choice_q       <= RST_IDX;
      choice_valid_q <= 1'b0;
    end else begin
      prev_left_q    <= bus.btn_left;
      prev_right_q   <= bus.btn_right;
      prev_confirm_q <= bus.btn_confirm;
      index_q        <= index_d;
      popup_q        <= popup_d;
      changed_q      <= changed_d;
      choice_q       <= choice_d;
      choice_valid_q <= choice_valid_d;
    end
  end

  assign bus.index         = index_q;
  assign bus.popup_message = popup_q;
  assign bus.changed       = changed_q;
  assign bus.choice        = choice_q;
  assign bus.choice_valid  = choice_valid_q;

endmodule

// File: doc/menu_selector.md
# menu_selector

Parametrised N-option menu selector, the generalised successor to the three-level difficulty picker. It sits between the debounced front-panel buttons and the game FSM, and steps a registered selection index left/right while the FSM asserts `enable`. It emits the 64-bit label of the current option for the popup renderer and latches a confirmed choice on a confirm press. Wrap-around, option count, reset option and label table are build-time parameters; hold-to-repeat is an optional compiled-in feature.

## Interface
- `NUM_OPTIONS`, 3: number of selectable options, 2..16.
- `IDX_W`, 2: index width; must satisfy 2^IDX_W >= NUM_OPTIONS.
- `RESET_INDEX`, 0: option selected after reset; must be < NUM_OPTIONS.
- `WRAP`, 0: 1 = stepping past either end wraps; 0 = saturate at the ends.
- `LABELS`, {"Hard","Medium","Easy"} (NUM_OPTIONS*64 bits): entry i is at bits [64*i+63 : 64*i], ASCII, right-aligned.
- `REPEAT_DELAY`, 24: hold cycles before the first auto-repeat step (only with the repeat macro).
- `REPEAT_RATE`, 8: cycles between subsequent auto-repeat steps (only with the repeat macro).

Ports:
- `clk` in 1: single clock; all state changes on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `enable` in 1: the FSM grants menu control.
- `btn_left` in 1: debounced level, step toward index 0.
- `btn_right` in 1: debounced level, step toward NUM_OPTIONS-1.
- `btn_confirm` in 1: debounced level, commit the current option.
- `index` out IDX_W: current highlighted option, registered.
- `popup_message` out 64: `LABELS` entry for `index`, registered and updated in the same cycle as `index`.
- `changed` out 1: one-cycle pulse, high in the cycle `index` takes a new value.
- `choice` out IDX_W: last confirmed option, registered.
- `choice_valid` out 1: one-cycle pulse, high in the cycle `choice` is written.

## Operation
- Each button has a registered previous-level flop. A press is a rising edge: level 1 and previous 0. Previous-level flops update every cycle, regardless of `enable`.
- A button held while `enable` rises does not act. It must be released and pressed again.
- With `enable` = 0: no steps, no confirms. All outputs hold, and pulses are 0.
- Left press: if `index` > 0, `index` -= 1. At 0 it goes to NUM_OPTIONS-1 if WRAP = 1, otherwise it stays.
- Right press: if `index` < NUM_OPTIONS-1, `index` += 1. At the top it goes to 0 if WRAP = 1, otherwise it stays.
- A saturated step (no index change) does not pulse `changed`.
- Left and right pressed in the same cycle: ignored, no change.
- Confirm press: `choice` <= `index` (the pre-step value if a step happens in the same cycle), and `choice_valid` pulses. A step in the same cycle is still applied.
- Arithmetic is done in IDX_W bits. Index values >= NUM_OPTIONS are never produced.

## Timing
- Press edge sampled at clock edge k: `index`, `popup_message` and `changed` update at edge k. That is 1-cycle latency from the button level going high.
- `choice`/`choice_valid` follow the same 1-cycle latency.
- Reset values: `index` = RESET_INDEX, `popup_message` = LABELS[RESET_INDEX], `changed` = 0, `choice` = RESET_INDEX, `choice_valid` = 0, previous-level flops = 0, repeat counters = 0.
- `rst` mid-hold or mid-repeat: everything returns to reset values. A button still held after reset counts as a new press on the first cycle after `rst` falls, because the previous-level flops are 0.

## Configuration
- Macro `MENU_SELECTOR_REPEAT_EN`.
- Defined: while exactly one direction button stays high with `enable` = 1:
  - a counter runs from the initial press;
  - an extra step occurs REPEAT_DELAY cycles after the press, then every REPEAT_RATE cycles;
  - each step obeys the WRAP/saturate rules.
  - The counter clears on release, on `enable` = 0, or when both buttons are high.
- Not defined: only edges step. The counter logic is absent, and REPEAT_* parameters are ignored.

## Test plan
- Reset with defaults -> `index` = 0, `popup_message` = "Easy", `choice` = 0, `changed` = 0, `choice_valid` = 0.
- WRAP = 0, right pressed three times -> `index` 1, 2, 2; `changed` pulses twice; `popup_message` ends "Hard".
- WRAP = 1, left press at `index` 0 -> `index` = 2, `changed` = 1 for one cycle.
- Right held high while `enable` rises -> no step. Release, then press -> `index` +1.
- Left and right high in the same cycle -> no change. Confirm at `index` 1 with right pressed in the same cycle -> `choice` = 1, `index` = 2, both pulses high.
- With `MENU_SELECTOR_REPEAT_EN`, REPEAT_DELAY = 4, REPEAT_RATE = 2, NUM_OPTIONS = 8, right held for 10 cycles -> steps at cycles 0, 4, 6, 8; `index` goes 0 to 4.
